// File: rtl/pc_pkg.sv
// Shared encodings for the PC/branch unit: instruction kinds, branch funct3 codes, FSM states.
package pc_pkg;

  localparam logic [1:0] KIND_SEQ  = 2'b00;
  localparam logic [1:0] KIND_BR   = 2'b01;
  localparam logic [1:0] KIND_JAL  = 2'b10;
  localparam logic [1:0] KIND_JALR = 2'b11;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {ST_RUN, ST_TRAP} state_t;

  // Instruction fetch requires word alignment.
  function automatic logic misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/pc_branch_unit_branch_cond.sv
// Branch condition evaluator: maps funct3 and ALU compare flags (from rs1 - rs2) to taken/not-taken.
module branch_cond
  import pc_pkg::*;
(
  input  logic [2:0] funct_three,
  input  logic       z,
  input  logic       n,
  input  logic       c,
  input  logic       v,
  output logic       cond
);

  always_comb begin
    cond = 1'b0;
    case (funct_three)
      F3_BEQ:  cond = z;
      F3_BNE:  cond = ~z;
      F3_BLT:  cond = n ^ v;
      F3_BGE:  cond = ~(n ^ v);
      F3_BLTU: cond = ~c;   // c=1 means no borrow, i.e. rs1 >= rs2 unsigned
      F3_BGEU: cond = c;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_branch_unit.sv
// Architectural PC register with branch/jump resolution, stall, and misaligned-target trap.
// Define PCBRANCH_STATS_EN to add saturating taken/not-taken counters for conditional branches.
module pc_branch_unit
  import pc_pkg::*;
#(
  parameter int          XLEN         = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int          CNT_W        = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            VALID,
  input  logic            STALL,
  input  logic [1:0]      KIND,
  input  logic [2:0]      FUNCT_THREE,
  input  logic [XLEN-1:0] OFFSET,
  input  logic [XLEN-1:0] RS1,
  input  logic            Z,
  input  logic            N,
  input  logic            C,
  input  logic            V,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] NEXTPC,
  output logic [XLEN-1:0] LINK,
  output logic            TAKEN,
  output logic            TRAP,
  output logic [XLEN-1:0] EPC
`ifdef PCBRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0] BR_TAKEN_CNT,
  output logic [CNT_W-1:0] BR_NTAKEN_CNT
`endif
);

  state_t            state_reg;
  logic [XLEN-1:0]   pc_reg;
  logic [XLEN-1:0]   epc_reg;
  logic              taken_reg;
  logic              trap_reg;

  logic              cond;
  logic [XLEN-1:0]   seq_pc;
  logic [XLEN-1:0]   rel_pc;
  logic [XLEN-1:0]   jalr_sum;
  logic [XLEN-1:0]   target;
  logic              jump;
  logic              mis;
  logic              accept;

  branch_cond u_branch_cond (
    .funct_three (FUNCT_THREE),
    .z           (Z),
    .n           (N),
    .c           (C),
    .v           (V),
    .cond        (cond)
  );

  assign seq_pc   = pc_reg + XLEN'(4);
  assign rel_pc   = pc_reg + OFFSET;
  assign jalr_sum = RS1 + OFFSET;

  always_comb begin
    target = seq_pc;
    jump   = 1'b0;
    case (KIND)
      KIND_BR: begin
        if (cond) begin
          target = rel_pc;
          jump   = 1'b1;
        end
      end
      KIND_JAL: begin
        target = rel_pc;
        jump   = 1'b1;
      end
      KIND_JALR: begin
        target = jalr_sum & {{(XLEN-1){1'b1}}, 1'b0};
        jump   = 1'b1;
      end
      default: ;
    endcase
  end

  assign mis    = misaligned(target[1:0]);
  assign accept = VALID & ~STALL & (state_reg == ST_RUN);

  always_comb begin
    NEXTPC = pc_reg;
    if (state_reg == ST_TRAP)
      NEXTPC = TRAP_VECTOR[XLEN-1:0];
    else if (accept && !mis)
      NEXTPC = target;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= ST_RUN;
      pc_reg    <= RESET_VECTOR[XLEN-1:0];
      epc_reg   <= '0;
      taken_reg <= 1'b0;
      trap_reg  <= 1'b0;
    end else begin
      taken_reg <= 1'b0;
      trap_reg  <= 1'b0;
      case (state_reg)
        ST_TRAP: begin
          // Single-cycle trap: redirect regardless of VALID/STALL.
          pc_reg    <= TRAP_VECTOR[XLEN-1:0];
          state_reg <= ST_RUN;
        end
        default: begin
          if (accept) begin
            if (mis) begin
              epc_reg   <= pc_reg;
              state_reg <= ST_TRAP;
              trap_reg  <= 1'b1;
            end else begin
              pc_reg    <= target;
              taken_reg <= jump;
            end
          end
        end
      endcase
    end
  end

`ifdef PCBRANCH_STATS_EN
  logic [CNT_W-1:0] br_taken_cnt_reg;
  logic [CNT_W-1:0] br_ntaken_cnt_reg;

  // A trapping conditional branch still resolved as taken, so it counts as taken.
  always_ff @(posedge CLK) begin
    if (RST) begin
      br_taken_cnt_reg  <= '0;
      br_ntaken_cnt_reg <= '0;
    end else if (accept && KIND == KIND_BR) begin
      if (cond) begin
        if (~&br_taken_cnt_reg)
          br_taken_cnt_reg <= br_taken_cnt_reg + CNT_W'(1);
      end else begin
        if (~&br_ntaken_cnt_reg)
          br_ntaken_cnt_reg <= br_ntaken_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign BR_TAKEN_CNT  = br_taken_cnt_reg;
  assign BR_NTAKEN_CNT = br_ntaken_cnt_reg;
`endif

  assign PC    = pc_reg;
  assign LINK  = pc_reg + XLEN'(4);
  assign TAKEN = taken_reg;
  assign TRAP  = trap_reg;
  assign EPC   = epc_reg;

endmodule
